// File: rtl/pairing_result_streamer_if.sv
// Beat stream carrying the captured pairing result (valid/ready handshake).
// The master side drives the beats and the slave side returns out_ready.
interface pairing_result_streamer_if #(
  parameter int unsigned CHUNK_W = 150,
  parameter int unsigned IDX_W   = 4
);
  logic               out_valid;
  logic               out_ready;
  logic [CHUNK_W-1:0] out_data;
  logic               out_last;
  logic [IDX_W-1:0]   out_idx;

  modport master (
    output out_valid, out_data, out_last, out_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_last, out_idx,
    output out_ready
  );
endinterface

// File: rtl/pairing_result_streamer.sv
// Captures the 1164-bit pairing result on cap and streams it as CHUNK_W-bit beats.
// Optional PAIRING_STREAM_CHKSUM_EN appends an XOR checksum beat (out_idx = NCHUNK).
module pairing_result_streamer #(
  parameter int unsigned IN_W      = 1164,
  parameter int unsigned CHUNK_W   = 150,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cap,
  input  logic [IN_W-1:0] in_data,
  input  logic            clr_ovr,
  output logic            busy,
  output logic            overrun,
  pairing_result_streamer_if.master strm
);
  localparam int unsigned NCHUNK = (IN_W + CHUNK_W - 1) / CHUNK_W;
  localparam int unsigned IDX_W  = $clog2(NCHUNK + 1);
  localparam int unsigned PAD_W  = NCHUNK * CHUNK_W;
  localparam logic [IDX_W-1:0] FIRST_IDX     = MSB_FIRST ? IDX_W'(NCHUNK - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_DATA_IDX = MSB_FIRST ? '0 : IDX_W'(NCHUNK - 1);
`ifdef PAIRING_STREAM_CHKSUM_EN
  localparam bit FIRST_LAST = 1'b0;
`else
  localparam bit FIRST_LAST = (NCHUNK == 1);
`endif

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state_q;
  logic [PAD_W-1:0]   cap_q;
  logic [PAD_W-1:0]   in_pad;
  logic [CHUNK_W-1:0] data_q;
  logic [CHUNK_W-1:0] first_chunk;
  logic [CHUNK_W-1:0] next_chunk;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   next_idx;
  logic               valid_q;
  logic               last_q;
  logic               ovr_q;
  logic               xfer;
  logic               cap_take;
`ifdef PAIRING_STREAM_CHKSUM_EN
  logic [CHUNK_W-1:0] chksum;
`endif

  always_comb begin
    in_pad = '0;
    in_pad[IN_W-1:0] = in_data;
    first_chunk = in_pad[int'(FIRST_IDX)*CHUNK_W +: CHUNK_W];
    next_idx = MSB_FIRST ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
    next_chunk = '0;
    if (int'(next_idx) < int'(NCHUNK)) begin
      next_chunk = cap_q[int'(next_idx)*CHUNK_W +: CHUNK_W];
    end
    xfer = valid_q & strm.out_ready;
    // A capture is only taken when idle or exactly as the final beat leaves.
    cap_take = cap & ((state_q == IDLE) | (xfer & last_q));
`ifdef PAIRING_STREAM_CHKSUM_EN
    chksum = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      chksum = chksum ^ cap_q[i*CHUNK_W +: CHUNK_W];
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cap_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      // Set is written after clear so a same-cycle overrun wins.
      if (clr_ovr) ovr_q <= 1'b0;
      if (cap && (state_q == STREAM) && !cap_take) ovr_q <= 1'b1;

      if (cap_take) begin
        cap_q   <= in_pad;
        data_q  <= first_chunk;
        idx_q   <= FIRST_IDX;
        last_q  <= FIRST_LAST;
        valid_q <= 1'b1;
        state_q <= STREAM;
      end else if (xfer) begin
        if (last_q) begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          data_q  <= '0;
          idx_q   <= '0;
          state_q <= IDLE;
        end
`ifdef PAIRING_STREAM_CHKSUM_EN
        else if (idx_q == LAST_DATA_IDX) begin
          idx_q  <= IDX_W'(NCHUNK);
          data_q <= chksum;
          last_q <= 1'b1;
        end else begin
          idx_q  <= next_idx;
          data_q <= next_chunk;
          last_q <= 1'b0;
        end
`else
        else begin
          idx_q  <= next_idx;
          data_q <= next_chunk;
          last_q <= (next_idx == LAST_DATA_IDX);
        end
`endif
      end
    end
  end

  assign strm.out_valid = valid_q;
  assign strm.out_data  = data_q;
  assign strm.out_last  = last_q;
  assign strm.out_idx   = idx_q;
  assign busy           = (state_q == STREAM);
  assign overrun        = ovr_q;
endmodule

// File: tb/tb_pairing_result_streamer.sv
// Directed bench for pairing_result_streamer: LSB-first and MSB-first instances,
// table-driven streams plus hand sequences for stall, overrun, back-to-back and reset.
module tb_pairing_result_streamer;
  localparam int unsigned IN_W    = 1164;
  localparam int unsigned CHUNK_W = 150;
  localparam int unsigned NCHUNK  = 8;
  localparam int unsigned IDX_W   = 4;
`ifdef PAIRING_STREAM_CHKSUM_EN
  localparam int NB = NCHUNK + 1;
`else
  localparam int NB = NCHUNK;
`endif

  typedef logic [IN_W-1:0] w_t;

  typedef struct packed {
    logic [IN_W-1:0]                   din;
    logic [NCHUNK-1:0][CHUNK_W-1:0]    beat;
    logic [CHUNK_W-1:0]                chk;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cap0 = 1'b0, cap1 = 1'b0;
  logic clr0 = 1'b0, clr1 = 1'b0;
  logic [IN_W-1:0] din0 = '0, din1 = '0;
  logic busy0, busy1, ovr0, ovr1;

  int checks = 0;
  int errors = 0;
  vec_t vecs [4];

  pairing_result_streamer_if #(.CHUNK_W(CHUNK_W), .IDX_W(IDX_W)) s0 ();
  pairing_result_streamer_if #(.CHUNK_W(CHUNK_W), .IDX_W(IDX_W)) s1 ();

  pairing_result_streamer #(.IN_W(IN_W), .CHUNK_W(CHUNK_W), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .cap(cap0), .in_data(din0), .clr_ovr(clr0),
    .busy(busy0), .overrun(ovr0), .strm(s0)
  );

  pairing_result_streamer #(.IN_W(IN_W), .CHUNK_W(CHUNK_W), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .reset(reset), .cap(cap1), .in_data(din1), .clr_ovr(clr1),
    .busy(busy1), .overrun(ovr1), .strm(s1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input w_t got, input w_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Stream one table entry through dut0 with optional stall / capture injection.
  task automatic run_stream(input int vi, input int stall_at, input int cap_at,
                            input int cap_vi, input bit clr_with_cap, input bit skip_cap);
    logic [CHUNK_W-1:0] e;
    if (!skip_cap) begin
      @(negedge clk);
      din0 = vecs[vi].din;
      cap0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cap0 = 1'b0;
    end
    for (int b = 0; b < NB; b++) begin
      e = (b < int'(NCHUNK)) ? vecs[vi].beat[b] : vecs[vi].chk;
      check("valid", w_t'(s0.out_valid), w_t'(1));
      check("idx", w_t'(s0.out_idx), w_t'(b));
      check("data", w_t'(s0.out_data), w_t'(e));
      check("last", w_t'(s0.out_last), w_t'(b == NB - 1));
      check("busy", w_t'(busy0), w_t'(1));
      if (b == stall_at) begin
        s0.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(posedge clk);
          @(negedge clk);
          check("stall_valid", w_t'(s0.out_valid), w_t'(1));
          check("stall_idx", w_t'(s0.out_idx), w_t'(b));
          check("stall_data", w_t'(s0.out_data), w_t'(e));
        end
        s0.out_ready = 1'b1;
      end
      if (b == cap_at) begin
        din0 = vecs[cap_vi].din;
        cap0 = 1'b1;
        clr0 = clr_with_cap;
      end
      @(posedge clk);
      @(negedge clk);
      cap0 = 1'b0;
      clr0 = 1'b0;
      if (b == cap_at && b != NB - 1) check("ovr_set", w_t'(ovr0), w_t'(1));
    end
    if (cap_at != NB - 1) begin
      check("end_valid", w_t'(s0.out_valid), w_t'(0));
      check("end_busy", w_t'(busy0), w_t'(0));
      check("end_last", w_t'(s0.out_last), w_t'(0));
    end
  endtask

  initial begin
    logic [NCHUNK*CHUNK_W-1:0] rebuilt;
    logic [IN_W-1:0] pat;
    int exp_idx;

    vecs[0].din = '0; vecs[0].din[0] = 1'b1;
    vecs[0].beat = '0; vecs[0].beat[0] = 150'h1;
    vecs[0].chk = 150'h1;

    vecs[1].din = '1;
    vecs[1].beat = '1; vecs[1].beat[7] = {36'b0, {114{1'b1}}};
    vecs[1].chk = {{36{1'b1}}, 114'b0};

    vecs[2].din = '0; vecs[2].din[1163] = 1'b1;
    vecs[2].beat = '0; vecs[2].beat[7][113] = 1'b1;
    vecs[2].chk = '0; vecs[2].chk[113] = 1'b1;

    vecs[3].din = '0; vecs[3].din[149] = 1'b1; vecs[3].din[150] = 1'b1;
    vecs[3].beat = '0; vecs[3].beat[0][149] = 1'b1; vecs[3].beat[1][0] = 1'b1;
    vecs[3].chk = '0; vecs[3].chk[149] = 1'b1; vecs[3].chk[0] = 1'b1;

    for (int i = 0; i < int'(IN_W); i++) pat[i] = (((i * 7) + (i / 13)) % 3 == 0);

    s0.out_ready = 1'b1;
    s1.out_ready = 1'b1;

    #1;
    check("rst_valid", w_t'(s0.out_valid), w_t'(0));
    check("rst_data", w_t'(s0.out_data), w_t'(0));
    check("rst_idx", w_t'(s0.out_idx), w_t'(0));
    check("rst_busy_ovr", w_t'({busy0, ovr0, s0.out_last}), w_t'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready_ignored", w_t'({s0.out_valid, busy0}), w_t'(0));

    for (int vi = 0; vi < 4; vi++) run_stream(vi, -1, -1, 0, 1'b0, 1'b0);

    run_stream(1, 2, -1, 0, 1'b0, 1'b0);

    check("ovr_idle", w_t'(ovr0), w_t'(0));
    run_stream(3, -1, 3, 1, 1'b0, 1'b0);
    check("ovr_sticky", w_t'(ovr0), w_t'(1));
    @(negedge clk); clr0 = 1'b1;
    @(posedge clk); @(negedge clk); clr0 = 1'b0;
    check("ovr_cleared", w_t'(ovr0), w_t'(0));

    run_stream(3, -1, NB - 1, 0, 1'b0, 1'b0);
    check("b2b_no_ovr", w_t'(ovr0), w_t'(0));
    run_stream(0, -1, -1, 0, 1'b0, 1'b1);

    run_stream(0, -1, 2, 1, 1'b1, 1'b0);
    check("ovr_set_wins", w_t'(ovr0), w_t'(1));

    @(negedge clk); din0 = vecs[1].din; cap0 = 1'b1;
    @(posedge clk); @(negedge clk); cap0 = 1'b0;
    repeat (5) begin @(posedge clk); @(negedge clk); end
    check("pre_rst_idx", w_t'(s0.out_idx), w_t'(5));
    #1 reset = 1'b1;
    #1;
    check("mid_rst_valid", w_t'(s0.out_valid), w_t'(0));
    check("mid_rst_busy", w_t'(busy0), w_t'(0));
    check("mid_rst_last", w_t'(s0.out_last), w_t'(0));
    check("mid_rst_idx_data", w_t'({s0.out_idx, s0.out_data}), w_t'(0));
    check("mid_rst_ovr", w_t'(ovr0), w_t'(0));
    @(negedge clk); reset = 1'b0;
    run_stream(1, -1, -1, 0, 1'b0, 1'b0);

    rebuilt = '1;
    @(negedge clk); din1 = pat; cap1 = 1'b1;
    @(posedge clk); @(negedge clk); cap1 = 1'b0;
    for (int b = 0; b < NB; b++) begin
      exp_idx = (b < int'(NCHUNK)) ? int'(NCHUNK) - 1 - b : int'(NCHUNK);
      check("msb_valid", w_t'(s1.out_valid), w_t'(1));
      check("msb_idx", w_t'(s1.out_idx), w_t'(exp_idx));
      check("msb_last", w_t'(s1.out_last), w_t'(b == NB - 1));
      if (int'(s1.out_idx) < int'(NCHUNK))
        rebuilt[int'(s1.out_idx)*CHUNK_W +: CHUNK_W] = s1.out_data;
      @(posedge clk); @(negedge clk);
    end
    check("msb_end_valid", w_t'(s1.out_valid), w_t'(0));
    check("msb_rebuild", rebuilt[IN_W-1:0], pat);
    check("msb_pad", w_t'(rebuilt[NCHUNK*CHUNK_W-1:IN_W]), w_t'(0));
    check("msb_ovr", w_t'(ovr1), w_t'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
